// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
package im_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_e;

  localparam int         WORD_BYTES    = 4;
  localparam logic [3:0] FULL_WORD_WEN = 4'hF;

endpackage

// File: rtl/im_loader_hold_cnt.sv
// rtl/im_loader_hold_cnt.sv - loadable down-counter with terminal-count flag
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   load, load_val load the counter (has priority over en)
//   en             decrement by one per cycle, saturating at zero
//   tc             high while the count is zero
module im_loader_hold_cnt #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - streams program words into instruction memory and sequences the CPU reset
// Optional feature macro: IM_LOADER_CHECKSUM_EN (adds checksum[31:0], running sum of loaded words)
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   load_start                     one-cycle pulse, starts a load from IDLE or RUN
//   s_valid, s_data, s_last        program word stream; s_ready back-pressure
//   im_w_en, im_address,
//   im_write_data                  registered IM write port (one cycle after each accepted beat)
//   cpu_rst                        active-high CPU reset, low only in RUN
//   busy, done, error              LOAD/HOLD, RUN, sticky overflow
module im_loader
  import im_loader_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                MAX_WORDS   = 1024,
  parameter int                HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [3:0]        im_w_en,
  output logic [ADDR_W-1:0] im_address,
  output logic [31:0]       im_write_data,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef IM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int                CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MAX_WORDS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  if (BASE_ADDR[1:0] != 2'b00) begin : g_base_align_err
    $error("im_loader: BASE_ADDR must be word aligned");
  end
  if ((longint'(BASE_ADDR) + longint'(WORD_BYTES) * longint'(MAX_WORDS)) >
      (longint'(1) << ADDR_W)) begin : g_range_err
    $error("im_loader: BASE_ADDR + 4*MAX_WORDS exceeds the IM address space");
  end
  if (HOLD_CYCLES < 1) begin : g_hold_err
    $error("im_loader: HOLD_CYCLES must be at least 1");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        im_w_en_q, im_w_en_d;
  logic [ADDR_W-1:0] im_address_q, im_address_d;
  logic [31:0]       im_write_data_q, im_write_data_d;
  logic              error_q, error_d;
  logic              accept, start, hold_tc;

  assign s_ready = (state_q == LOAD);
  assign accept  = s_valid && s_ready;
  // load_start only counts where a load can begin; it is ignored in LOAD and HOLD.
  assign start   = load_start && ((state_q == IDLE) || (state_q == RUN));

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    error_d         = error_q;
    im_w_en_d       = '0;
    im_address_d    = im_address_q;
    im_write_data_d = im_write_data_q;
    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          error_d = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          im_w_en_d       = FULL_WORD_WEN;
          im_address_d    = BASE_ADDR + ADDR_W'(cnt_q) * ADDR_W'(WORD_BYTES);
          im_write_data_d = s_data;
          cnt_d           = cnt_q + CNT_W'(1);
          if (s_last) begin
            state_d = HOLD;
          end else if (cnt_q == LAST_CNT) begin
            // Capacity reached without s_last: keep the word, flag it, leave the CPU in reset.
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (hold_tc) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      im_w_en_q       <= '0;
      im_address_q    <= BASE_ADDR;
      im_write_data_q <= '0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      im_w_en_q       <= im_w_en_d;
      im_address_q    <= im_address_d;
      im_write_data_q <= im_write_data_d;
      error_q         <= error_d;
    end
  end

  // Loaded with HOLD_CYCLES-1 on the final beat: the first HOLD cycle carries the last
  // write, and RUN begins exactly HOLD_CYCLES cycles after it.
  im_loader_hold_cnt #(
    .WIDTH (HOLD_W)
  ) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && s_last),
    .load_val (HOLD_LOAD),
    .en       (state_q == HOLD),
    .tc       (hold_tc)
  );

`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start)       checksum_d = '0;
    else if (accept) checksum_d = checksum_q + s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) checksum_q <= '0;
    else      checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

  assign im_w_en       = im_w_en_q;
  assign im_address    = im_address_q;
  assign im_write_data = im_write_data_q;
  assign error         = error_q;
  assign busy          = (state_q == LOAD) || (state_q == HOLD);
  assign done          = (state_q == RUN);
  // The reset reasserts in the very cycle of a reload pulse so the CPU never fetches mid-load.
  assign cpu_rst       = (state_q != RUN) || load_start;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - directed self-checking bench for im_loader
module tb_im_loader;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic [3:0]  im_w_en;
  logic [15:0] im_address;
  logic [31:0] im_write_data;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  im_loader #(
    .ADDR_W      (16),
    .BASE_ADDR   (16'h0000),
    .MAX_WORDS   (4),
    .HOLD_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .im_w_en       (im_w_en),
    .im_address    (im_address),
    .im_write_data (im_write_data),
    .cpu_rst       (cpu_rst),
    .busy          (busy),
    .done          (done),
    .error         (error)
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic drive(input logic st, input logic v, input logic [31:0] d, input logic l);
    @(posedge clk);
    #1;
    load_start = st;
    s_valid    = v;
    s_data     = d;
    s_last     = l;
    @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input logic [15:0] addr, input logic [31:0] data);
    chk({tag, "_wen"},  32'(im_w_en),    32'hF);
    chk({tag, "_addr"}, 32'(im_address), 32'(addr));
    chk({tag, "_data"}, im_write_data,   data);
  endtask

  // Called in the cycle carrying the final write: three more reset cycles, then RUN.
  task automatic hold_then_run(input string tag);
    chk({tag, "_rst_w"}, 32'(cpu_rst), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk({tag, "_hold_rst"}, 32'(cpu_rst), 32'd1);
      chk({tag, "_hold_wen"}, 32'(im_w_en), 32'h0);
      chk({tag, "_hold_rdy"}, 32'(s_ready), 32'd0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk({tag, "_run_rst"},  32'(cpu_rst), 32'd0);
    chk({tag, "_run_done"}, 32'(done),    32'd1);
    chk({tag, "_run_busy"}, 32'(busy),    32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    load_start = 1'b0;
    s_valid    = 1'b0;
    s_data     = 32'h0;
    s_last     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wen",   32'(im_w_en),    32'h0);
    chk("rst_addr",  32'(im_address), 32'h0);
    chk("rst_data",  im_write_data,   32'h0);
    chk("rst_ready", 32'(s_ready),    32'd0);
    chk("rst_cpu",   32'(cpu_rst),    32'd1);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_done",  32'(done),       32'd0);
    chk("rst_err",   32'(error),      32'd0);
`ifdef IM_LOADER_CHECKSUM_EN
    chk("rst_csum",  checksum,        32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: three back-to-back words
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t1_idle_rdy", 32'(s_ready), 32'd0);
    chk("t1_idle_rst", 32'(cpu_rst), 32'd1);
    drive(1'b0, 1'b1, 32'h00500093, 1'b0);
    chk("t1_rdy",  32'(s_ready), 32'd1);
    chk("t1_busy", 32'(busy),    32'd1);
    chk("t1_nowr", 32'(im_w_en), 32'h0);
    drive(1'b0, 1'b1, 32'h00100113, 1'b0);
    chk_wr("t1_w0", 16'h0000, 32'h00500093);
    drive(1'b0, 1'b1, 32'h002081B3, 1'b1);
    chk_wr("t1_w1", 16'h0004, 32'h00100113);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_wr("t1_w2", 16'h0008, 32'h002081B3);
    hold_then_run("t1");

    // 5: reload from RUN with one word
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t5_pulse_rst", 32'(cpu_rst), 32'd1);
    drive(1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    chk("t5_rdy",  32'(s_ready), 32'd1);
    chk("t5_done", 32'(done),    32'd0);
    chk("t5_rst",  32'(cpu_rst), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_wr("t5_w0", 16'h0000, 32'hDEADBEEF);
    hold_then_run("t5");

    // 2: same program with two idle cycles between beats
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h00500093, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_wr("t2_w0", 16'h0000, 32'h00500093);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_gap0", 32'(im_w_en), 32'h0);
    chk("t2_gap_rdy", 32'(s_ready), 32'd1);
    drive(1'b0, 1'b1, 32'h00100113, 1'b0);
    chk("t2_acc1_nowr", 32'(im_w_en), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_wr("t2_w1", 16'h0004, 32'h00100113);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_gap1", 32'(im_w_en), 32'h0);
    drive(1'b0, 1'b1, 32'h002081B3, 1'b1);
    chk("t2_acc2_nowr", 32'(im_w_en), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_wr("t2_w2", 16'h0008, 32'h002081B3);
    hold_then_run("t2");

    // 3: overflow with MAX_WORDS=4
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h11111111, 1'b0);
    drive(1'b0, 1'b1, 32'h22222222, 1'b0);
    chk_wr("t3_w0", 16'h0000, 32'h11111111);
    drive(1'b0, 1'b1, 32'h33333333, 1'b0);
    chk_wr("t3_w1", 16'h0004, 32'h22222222);
    drive(1'b0, 1'b1, 32'h44444444, 1'b0);
    chk_wr("t3_w2", 16'h0008, 32'h33333333);
    chk("t3_err_pre", 32'(error), 32'd0);
    drive(1'b0, 1'b1, 32'h55555555, 1'b0);
    chk_wr("t3_w3", 16'h000C, 32'h44444444);
    chk("t3_err",  32'(error),   32'd1);
    chk("t3_rdy",  32'(s_ready), 32'd0);
    chk("t3_busy", 32'(busy),    32'd0);
    chk("t3_rst",  32'(cpu_rst), 32'd1);
    drive(1'b0, 1'b1, 32'h55555555, 1'b0);
    chk("t3_w4_none", 32'(im_w_en), 32'h0);
    chk("t3_err_stk", 32'(error),   32'd1);
    chk("t3_done",    32'(done),    32'd0);

    // 3b: exactly MAX_WORDS with s_last on the last word, error cleared by the new load
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'hA0000001, 1'b0);
    chk("t3b_err_clr", 32'(error), 32'd0);
    drive(1'b0, 1'b1, 32'hA0000002, 1'b0);
    drive(1'b0, 1'b1, 32'hA0000003, 1'b0);
    drive(1'b0, 1'b1, 32'hA0000004, 1'b1);
    chk_wr("t3b_w2", 16'h0008, 32'hA0000003);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_wr("t3b_w3", 16'h000C, 32'hA0000004);
    chk("t3b_err",  32'(error), 32'd0);
    chk("t3b_busy", 32'(busy),  32'd1);
    hold_then_run("t3b");

    // 4: reset asserted two cycles into a six-word load
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'hB0000001, 1'b0);
    drive(1'b0, 1'b1, 32'hB0000002, 1'b0);
    chk_wr("t4_w0", 16'h0000, 32'hB0000001);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    s_data = 32'hB0000003;
    #1;
    chk("t4_async_wen", 32'(im_w_en), 32'h0);
    @(negedge clk);
    chk("t4_rst_wen",  32'(im_w_en),   32'h0);
    chk("t4_rst_data", im_write_data,  32'h0);
    chk("t4_rst_cpu",  32'(cpu_rst),   32'd1);
    chk("t4_rst_busy", 32'(busy),      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'hB0000004, 1'b0);
      chk("t4_idle_wen",  32'(im_w_en), 32'h0);
      chk("t4_idle_rdy",  32'(s_ready), 32'd0);
      chk("t4_idle_busy", 32'(busy),    32'd0);
      chk("t4_idle_done", 32'(done),    32'd0);
      chk("t4_idle_rst",  32'(cpu_rst), 32'd1);
    end

`ifdef IM_LOADER_CHECKSUM_EN
    // 6: checksum wraps modulo 2^32 and clears on the next load
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
    chk("t6_csum_clr", checksum, 32'h0);
    drive(1'b0, 1'b1, 32'h00000002, 1'b1);
    chk("t6_csum_1", checksum, 32'hFFFFFFFF);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t6_csum", checksum, 32'h00000001);
    hold_then_run("t6");
    chk("t6_csum_run", checksum, 32'h00000001);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t6_csum_reload", checksum, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time writer for the instruction memory; it is the write side of the IM port that the CPU's fetch stage reads.
- Accepts a valid/ready word stream of program code and writes it into IM using full-word byte enables at consecutive word addresses.
- Holds the CPU in reset while loading, then releases it so fetch starts from BASE_ADDR.
- Sits between the program source (bench or host bridge) and the IM write port (w_en, address, write_data).

Parameters:
- ADDR_W, 16, IM byte-address width; matches the IM address port.
- BASE_ADDR, 16'h0000, byte address of the first loaded word; must be 4-byte aligned.
- MAX_WORDS, 1024, capacity in 32-bit words; a stream longer than this is an overflow.
- HOLD_CYCLES, 4, cycles cpu_rst stays high after the last IM write, so the CPU pipeline sees a clean reset.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse; starts a new load.
- s_valid  in  1  stream word valid.
- s_data  in  32  stream word; little-endian instruction.
- s_last  in  1  marks the final word of the program.
- s_ready  out  1  loader can accept a word.
- im_w_en  out  4  IM byte write enables.
- im_address  out  ADDR_W  IM byte address.
- im_write_data  out  32  IM write data.
- cpu_rst  out  1  active-high reset to the CPU.
- busy  out  1  high in LOAD or HOLD.
- done  out  1  high in RUN.
- error  out  1  sticky overflow flag.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, word counter cnt=0.
  - im_w_en=0, im_address=BASE_ADDR, im_write_data=0.
  - s_ready=0, cpu_rst=1, busy=0, done=0, error=0.
  - A reset during LOAD kills any pending write immediately; no partial write leaves the block after rst falls.
- IDLE:
  - cpu_rst=1, s_ready=0.
  - load_start -> LOAD; cnt=0, error cleared.
- LOAD:
  - s_ready=1. A beat is accepted when s_valid && s_ready.
  - Write latency is 1 cycle, registered. The cycle after an accepted beat: im_w_en=4'hF, im_address=BASE_ADDR+4*cnt, im_write_data=s_data; cnt increments.
  - im_w_en=0 in every cycle without an accepted beat in the previous cycle.
  - Back-to-back beats give one write per cycle.
  - Accepted beat with s_last -> HOLD.
  - Accepted beat with cnt==MAX_WORDS-1 and !s_last: the word is still written; error=1; -> IDLE (CPU stays in reset).
  - load_start in LOAD is ignored.
- HOLD:
  - s_ready=0. A down-counter runs HOLD_CYCLES cycles after the final write, then -> RUN.
  - cpu_rst stays 1 for the whole HOLD.
- RUN:
  - cpu_rst=0, done=1, s_ready=0.
  - load_start -> LOAD: cpu_rst=1 in the same cycle (combinational from the pulse), done=0, cnt=0.
- Address arithmetic: im_address width is ADDR_W and wraps modulo 2^ADDR_W. BASE_ADDR+4*MAX_WORDS exceeding 2^ADDR_W is a configuration error, checked by an elaboration-time assertion.
- A zero-length program is impossible: s_last always carries a word.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- When defined, the block adds output port checksum[31:0]:
  - checksum is the mod-2^32 sum of all words accepted in the current load.
  - It clears on load_start and holds its value in HOLD, RUN and IDLE.
  - Reset value is 0.
- When undefined, the port and adder are absent and all other behaviour is identical.

Decomposition:
- Shared package im_loader_pkg holds:
  - state enum {IDLE, LOAD, HOLD, RUN};
  - constant WORD_BYTES=4;
  - constant FULL_WORD_WEN=4'hF.
- One sub-module: im_loader_hold_cnt, a loadable down-counter with a terminal-count flag, used for HOLD_CYCLES.
- The FSM and datapath stay in im_loader.

Test Plan:
1. Reset, then load_start; stream 3 words 0x00500093, 0x00100113, 0x002081B3 (last on the 3rd), s_valid held high.
   -> im_w_en=F at addresses 0x0000, 0x0004, 0x0008 on 3 consecutive cycles; cpu_rst falls exactly 4 cycles after the last write; done=1.
2. Same 3 words with s_valid gaps of 2 cycles between beats.
   -> exactly 3 writes, each 1 cycle after its accept; no writes during gaps.
3. MAX_WORDS=4; stream 5 words, no s_last by word 4.
   -> 4 writes (0x0..0xC); error=1 after the 4th; state IDLE; cpu_rst stays 1; the 5th beat is not accepted (s_ready=0).
4. Assert rst low two cycles into a 6-word load.
   -> im_w_en=0 immediately (asynchronous); cpu_rst=1; after release the block is in IDLE with no further writes.
5. In RUN, pulse load_start and reload 1 word 0xDEADBEEF.
   -> cpu_rst=1 in the pulse cycle; a single write at BASE_ADDR; cpu_rst released 4 cycles later.
6. With IM_LOADER_CHECKSUM_EN: load 0xFFFFFFFF, 0x00000002.
   -> checksum=0x00000001 (wrap); a later load_start clears it to 0.
